// File: rtl/uart_mem_bridge_pkg.sv
// Shared definitions for the UART memory bridge: FSM state encoding,
// response byte codes and the header opcodes shared with the packet receiver.
// No ports; imported by uart_mem_bridge and uart_word_serializer.
package uart_mem_bridge_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_MEM_REQ = 2'd1,
    ST_TX_LOAD = 2'd2,
    ST_TX_WAIT = 2'd3
  } state_t;

  localparam logic [7:0] ACK_BYTE = 8'h06;
  localparam logic [7:0] NAK_BYTE = 8'h15;

  // Header opcodes, identical to the receiver's decode.
  localparam logic [1:0] OP_WRITE = 2'b11;
  localparam logic [1:0] OP_READ  = 2'b01;

  // Width of the byte counter / byte-count field (covers 1..4 bytes).
  localparam int CNT_W = 3;

endpackage

// File: rtl/uart_word_serializer.sv
// Word-to-byte serializer: holds a 32-bit word, emits it MSB byte first to the
// UART transmitter with a registered one-cycle tx_start per byte.
// Ports: load/word/nbytes capture a new response; send/wait_en come from the
// owning FSM's TX_LOAD/TX_WAIT states; byte_sent/done report handshake progress.
module uart_word_serializer
  import uart_mem_bridge_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [31:0]      word,
  input  logic [CNT_W-1:0] nbytes,
  input  logic             send,
  input  logic             wait_en,
  input  logic             tx_busy,
  output logic             tx_start,
  output logic [7:0]       tx_data,
  output logic             byte_sent,
  output logic             done
);

  logic [31:0]      shift_q;
  logic [CNT_W-1:0] byte_cnt;
  logic [CNT_W-1:0] nbytes_q;
  logic             busy_seen;
  logic             fire;
  logic             last;

  // A byte is launched only when the transmitter is idle.
  assign fire      = send & ~tx_busy;
  assign last      = (byte_cnt == nbytes_q - 1'b1);
  // A byte is finished once tx_busy has been seen high and then low again.
  assign byte_sent = wait_en & busy_seen & ~tx_busy;
  assign done      = byte_sent & last;
  assign tx_data   = shift_q[31:24];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shift_q   <= '0;
      byte_cnt  <= '0;
      nbytes_q  <= '0;
      busy_seen <= 1'b0;
      tx_start  <= 1'b0;
    end else begin
      tx_start <= fire;
      if (load) begin
        shift_q   <= word;
        byte_cnt  <= '0;
        nbytes_q  <= nbytes;
        busy_seen <= 1'b0;
      end else begin
        if (fire || byte_sent) begin
          busy_seen <= 1'b0;
        end else if (wait_en && tx_busy) begin
          busy_seen <= 1'b1;
        end
        // Counter stops at the last byte, so it never wraps.
        if (byte_sent && !last) begin
          shift_q  <= {shift_q[23:0], 8'h00};
          byte_cnt <= byte_cnt + 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/uart_mem_bridge.sv
// UART-to-memory bridge: runs one CPU memory access per decoded UART command
// and returns read data (MSB byte first), an optional write ACK, or a timeout NAK.
// Ports: cmd_* from the receiver, mem_* to the CPU memory port, tx_* to the
// byte transmitter, cpu_hold stall, sticky cmd_overrun / mem_timeout flags.
// Build option: define UART_BRIDGE_WR_ACK_EN to answer completed writes with 0x06.
module uart_mem_bridge
  import uart_mem_bridge_pkg::*;
#(
  parameter int BYTE_COUNT  = 4,
  parameter int MEM_TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        cmd_valid,
  input  logic        cmd_rw,
  input  logic        cmd_mem_type,
  input  logic [8:0]  cmd_addr,
  input  logic [31:0] cmd_wdata,
  output logic        mem_req,
  output logic        mem_we,
  output logic        mem_sel,
  output logic [8:0]  mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  input  logic        mem_ready,
  output logic        tx_start,
  output logic [7:0]  tx_data,
  input  logic        tx_busy,
  output logic        cpu_hold,
  output logic        cmd_overrun,
  output logic        mem_timeout
);

  state_t           state, state_nxt;
  logic             rw_q;
  logic [7:0]       wait_cnt;
  logic             timeout_hit;
  logic             ser_load;
  logic [31:0]      ser_word;
  logic [CNT_W-1:0] ser_nbytes;
  logic             ser_byte_sent;
  logic             ser_done;

  assign mem_req  = (state == ST_MEM_REQ);
  assign mem_we   = mem_req & rw_q;
  assign cpu_hold = (state != ST_IDLE);

  // Current MEM_REQ cycle is the MEM_TIMEOUT-th one.
  assign timeout_hit = (({1'b0, wait_cnt} + 9'd1) == 9'(MEM_TIMEOUT));

  always_comb begin
    state_nxt  = state;
    ser_load   = 1'b0;
    ser_word   = mem_rdata;
    ser_nbytes = CNT_W'(BYTE_COUNT);
    case (state)
      ST_IDLE: begin
        if (cmd_valid) state_nxt = ST_MEM_REQ;
      end
      ST_MEM_REQ: begin
        // mem_ready takes priority over a coincident timeout.
        if (mem_ready) begin
          if (!rw_q) begin
            ser_load  = 1'b1;
            state_nxt = ST_TX_LOAD;
          end else begin
`ifdef UART_BRIDGE_WR_ACK_EN
            ser_load   = 1'b1;
            ser_word   = {ACK_BYTE, 24'h0};
            ser_nbytes = CNT_W'(1);
            state_nxt  = ST_TX_LOAD;
`else
            state_nxt  = ST_IDLE;
`endif
          end
        end else if (timeout_hit) begin
          ser_load   = 1'b1;
          ser_word   = {NAK_BYTE, 24'h0};
          ser_nbytes = CNT_W'(1);
          state_nxt  = ST_TX_LOAD;
        end
      end
      ST_TX_LOAD: begin
        if (!tx_busy) state_nxt = ST_TX_WAIT;
      end
      ST_TX_WAIT: begin
        if (ser_done)           state_nxt = ST_IDLE;
        else if (ser_byte_sent) state_nxt = ST_TX_LOAD;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= ST_IDLE;
      rw_q        <= 1'b0;
      mem_sel     <= 1'b0;
      mem_addr    <= '0;
      mem_wdata   <= '0;
      wait_cnt    <= '0;
      cmd_overrun <= 1'b0;
      mem_timeout <= 1'b0;
    end else begin
      state <= state_nxt;
      if (cmd_valid) begin
        if (state == ST_IDLE) begin
          rw_q      <= cmd_rw;
          mem_sel   <= cmd_mem_type;
          mem_addr  <= cmd_addr;
          mem_wdata <= cmd_wdata;
          wait_cnt  <= '0;
        end else begin
          cmd_overrun <= 1'b1;
        end
      end
      if (state == ST_MEM_REQ) begin
        wait_cnt <= wait_cnt + 8'd1;
        if (!mem_ready && timeout_hit) mem_timeout <= 1'b1;
      end
    end
  end

  uart_word_serializer u_ser (
    .clk       (clk),
    .rst_n     (rst_n),
    .load      (ser_load),
    .word      (ser_word),
    .nbytes    (ser_nbytes),
    .send      (state == ST_TX_LOAD),
    .wait_en   (state == ST_TX_WAIT),
    .tx_busy   (tx_busy),
    .tx_start  (tx_start),
    .tx_data   (tx_data),
    .byte_sent (ser_byte_sent),
    .done      (ser_done)
  );

endmodule

// File: tb/tb_uart_mem_bridge.sv
// Testbench for uart_mem_bridge: memory and transmitter models, expected
// response bytes queued at command issue, checked by an independent tx monitor.
module tb_uart_mem_bridge;

  localparam int TB_TIMEOUT = 8;

  logic        clk;
  logic        rst_n;
  logic        cmd_valid;
  logic        cmd_rw;
  logic        cmd_mem_type;
  logic [8:0]  cmd_addr;
  logic [31:0] cmd_wdata;
  logic        mem_req;
  logic        mem_we;
  logic        mem_sel;
  logic [8:0]  mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic        mem_ready;
  logic        tx_start;
  logic [7:0]  tx_data;
  logic        tx_busy;
  logic        cpu_hold;
  logic        cmd_overrun;
  logic        mem_timeout;

  logic        tx_model_busy;
  logic        bp_busy;
  assign tx_busy = tx_model_busy | bp_busy;

  int checks   = 0;
  int failures = 0;
  int tx_cnt   = 0;
  logic [7:0] exp_q[$];

  uart_mem_bridge #(.BYTE_COUNT(4), .MEM_TIMEOUT(TB_TIMEOUT)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .cmd_valid    (cmd_valid),
    .cmd_rw       (cmd_rw),
    .cmd_mem_type (cmd_mem_type),
    .cmd_addr     (cmd_addr),
    .cmd_wdata    (cmd_wdata),
    .mem_req      (mem_req),
    .mem_we       (mem_we),
    .mem_sel      (mem_sel),
    .mem_addr     (mem_addr),
    .mem_wdata    (mem_wdata),
    .mem_rdata    (mem_rdata),
    .mem_ready    (mem_ready),
    .tx_start     (tx_start),
    .tx_data      (tx_data),
    .tx_busy      (tx_busy),
    .cpu_hold     (cpu_hold),
    .cmd_overrun  (cmd_overrun),
    .mem_timeout  (mem_timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic fail_bound(input string name);
    checks++;
    failures++;
    $display("FAIL %s wait bound expired", name);
  endtask

  // Transmitter model: busy rises the cycle after tx_start, stays 1..4 cycles.
  initial begin
    tx_model_busy = 1'b0;
    forever begin
      @(negedge clk);
      if (rst_n && tx_start) begin
        int len;
        len = $urandom_range(1, 4);
        @(posedge clk); #1;
        tx_model_busy = 1'b1;
        repeat (len) @(posedge clk);
        #1 tx_model_busy = 1'b0;
      end
    end
  end

  // Monitor: every tx_start must match the oldest expected byte.
  initial begin
    forever begin
      @(negedge clk);
      if (rst_n && tx_start) begin
        tx_cnt++;
        check("tx_start_while_busy", 32'(tx_busy), 32'(0));
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL tx_unexpected actual=%h required=none", tx_data);
        end else begin
          check("tx_byte", 32'(tx_data), 32'(exp_q.pop_front()));
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic wait_idle(input string name);
    int n = 0;
    while (cpu_hold !== 1'b0 && n < 2000) begin
      @(posedge clk); #1;
      n++;
    end
    if (n >= 2000) fail_bound(name);
  endtask

  // One command end to end. lat >= TB_TIMEOUT means the memory never answers.
  task automatic run_cmd(input bit rw, input bit typ, input logic [8:0] addr,
                         input logic [31:0] wdata, input logic [31:0] rdata,
                         input int lat, input bit ovr, input bit bp);
    int n;
    int base;
    @(posedge clk); #1;
    cmd_valid = 1'b1; cmd_rw = rw; cmd_mem_type = typ;
    cmd_addr = addr;  cmd_wdata = wdata;
    if (bp) bp_busy = 1'b1;
    if (lat >= TB_TIMEOUT) begin
      exp_q.push_back(8'h15);
    end else if (!rw) begin
      for (int i = 0; i < 4; i++) exp_q.push_back(8'(rdata >> (24 - 8 * i)));
    end else begin
`ifdef UART_BRIDGE_WR_ACK_EN
      exp_q.push_back(8'h06);
`endif
    end
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    cmd_wdata = $urandom;
    cmd_addr  = 9'($urandom_range(0, 511));
    check("cpu_hold_rise", 32'(cpu_hold), 32'(1));
    check("mem_req",       32'(mem_req),  32'(1));
    check("mem_we",        32'(mem_we),   32'(rw));
    check("mem_sel",       32'(mem_sel),  32'(typ));
    check("mem_addr",      32'(mem_addr), 32'(addr));
    check("mem_wdata",     mem_wdata,     wdata);
    if (lat < TB_TIMEOUT) begin
      repeat (lat) begin
        @(posedge clk); #1;
      end
      check("mem_req_held", 32'(mem_req), 32'(1));
      mem_ready = 1'b1;
      mem_rdata = rdata;
      @(posedge clk); #1;
      mem_ready = 1'b0;
      mem_rdata = $urandom;
      check("cpu_hold_after_ready", 32'(cpu_hold), 32'(rw ? 1'b0 : 1'b1) | 32'(cpu_hold & rw));
    end else begin
      n = 1;
      while (mem_req === 1'b1 && n < 300) begin
        @(posedge clk); #1;
        if (mem_req === 1'b1) n++;
      end
      check("timeout_req_cycles", 32'(n), 32'(TB_TIMEOUT));
      check("mem_timeout_flag", 32'(mem_timeout), 32'(1));
    end
    if (bp) begin
      base = tx_cnt;
      repeat (50) begin
        @(posedge clk); #1;
      end
      check("bp_no_start", 32'(tx_cnt), 32'(base));
      bp_busy = 1'b0;
    end
    if (ovr) begin
      n = 0;
      while (tx_start !== 1'b1 && n < 200) begin
        @(posedge clk); #1;
        n++;
      end
      if (n >= 200) fail_bound("ovr_wait_tx");
      repeat (2) begin
        @(posedge clk); #1;
      end
      cmd_valid = 1'b1; cmd_rw = 1'b1; cmd_mem_type = 1'b1;
      cmd_addr = 9'h0AA; cmd_wdata = 32'hCAFEF00D;
      @(posedge clk); #1;
      cmd_valid = 1'b0;
      check("cmd_overrun_set", 32'(cmd_overrun), 32'(1));
    end
    wait_idle("wait_idle");
    repeat (3) begin
      @(posedge clk); #1;
    end
    check("idle_no_req", 32'(mem_req), 32'(0));
    check("queue_drained", 32'(exp_q.size()), 32'(0));
    exp_q.delete();
  endtask

  initial begin
    int n;
    logic [31:0] rnd;
    rst_n = 1'b0; cmd_valid = 1'b0; cmd_rw = 1'b0; cmd_mem_type = 1'b0;
    cmd_addr = '0; cmd_wdata = '0; mem_rdata = '0; mem_ready = 1'b0; bp_busy = 1'b0;
    #12;
    check("rst_outputs", {mem_req, mem_we, mem_sel, mem_addr, tx_start, tx_data,
                          cpu_hold, cmd_overrun, mem_timeout}, 32'(0));
    check("rst_wdata", mem_wdata, 32'(0));
    @(posedge clk); #3 rst_n = 1'b1;

    // Directed write, read, timeout, overrun and back-pressure cases.
    run_cmd(1'b1, 1'b1, 9'h05A, 32'hDEADBEEF, 32'h0, 3, 1'b0, 1'b0);
    run_cmd(1'b0, 1'b0, 9'h1FF, 32'h0, 32'h12345678, 2, 1'b0, 1'b0);
    check("mem_timeout_clear", 32'(mem_timeout), 32'(0));
    run_cmd(1'b0, 1'b1, 9'h003, 32'h0, 32'h0, TB_TIMEOUT, 1'b0, 1'b0);
    run_cmd(1'b0, 1'b0, 9'h100, 32'h0, 32'hA5C3_0F81, TB_TIMEOUT - 1, 1'b0, 1'b0);
    check("cmd_overrun_clear", 32'(cmd_overrun), 32'(0));
    run_cmd(1'b0, 1'b1, 9'h0F0, 32'h0, 32'h8899AABB, 1, 1'b1, 1'b0);
    run_cmd(1'b0, 1'b0, 9'h011, 32'h0, 32'h01020304, 0, 1'b0, 1'b1);

    // Randomized commands.
    for (int k = 0; k < 24; k++) begin
      rnd = $urandom;
      run_cmd(rnd[0], rnd[1], 9'($urandom_range(0, 511)), $urandom, $urandom,
              $urandom_range(0, TB_TIMEOUT + 1), 1'b0, 1'b0);
    end

    // Reset during the second response byte of a read.
    @(posedge clk); #1;
    cmd_valid = 1'b1; cmd_rw = 1'b0; cmd_mem_type = 1'b0; cmd_addr = 9'h077;
    exp_q.push_back(8'hFE); exp_q.push_back(8'hDC);
    exp_q.push_back(8'hBA); exp_q.push_back(8'h98);
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    @(posedge clk); #1;
    mem_ready = 1'b1; mem_rdata = 32'hFEDCBA98;
    @(posedge clk); #1;
    mem_ready = 1'b0;
    n = 0;
    while (tx_cnt < 2 + (tx_cnt - (tx_cnt % 1)) - tx_cnt + n * 0 && n < 0) n++;
    begin
      int base;
      base = tx_cnt;
      n = 0;
      while (tx_cnt < base + 2 && n < 200) begin
        @(posedge clk); #1;
        n++;
      end
      if (n >= 200) fail_bound("rst_wait_second_byte");
    end
    #3 rst_n = 1'b0;
    #1;
    check("async_rst_outputs", {mem_req, mem_we, mem_sel, mem_addr, tx_start, tx_data,
                                cpu_hold, cmd_overrun, mem_timeout}, 32'(0));
    check("async_rst_wdata", mem_wdata, 32'(0));
    exp_q.delete();
    repeat (2) @(posedge clk);
    #3 rst_n = 1'b1;
    repeat (6) begin
      @(posedge clk); #1;
    end
    run_cmd(1'b0, 1'b1, 9'h1A5, 32'h0, 32'h5A6B7C8D, 4, 1'b0, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
